// File: rtl/req_ack_arbiter.sv
// Purpose : round-robin arbiter sharing one four-phase req/ack responder among N_REQ requesters,
//           with a watchdog that aborts a REQ phase left unanswered for TIMEOUT cycles.
// Latency : req sampled at edge k -> gnt/m_req from edge k; m_ack -> ack[winner] one cycle later.
// Flow    : non-winning requests wait (level-held) until the FSM is back in IDLE; one IDLE cycle between grants.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous reset, active HIGH (legacy name kept for the surrounding codebase)
//   req[i]       level request from requester i (four-phase)
//   ack[i]       ack back to requester i, only ever at the granted index
//   gnt          one-hot grant, zero when idle
//   m_req/m_ack  four-phase handshake with the shared responder
//   busy         FSM is not in IDLE
//   timeout_err  one-cycle pulse when the watchdog aborts a transaction
//   err_id       index of the requester aborted by the most recent timeout (held)
module req_ack_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 16,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [N_REQ-1:0] gnt,
    output logic             m_req,
    input  logic             m_ack,
    output logic             busy,
    output logic             timeout_err,
    output logic [ID_W-1:0]  err_id
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so TIMEOUT 0/1 still elaborate.
    localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_ack;
    logic             r_m_req;
    logic             r_busy;
    logic             r_terr;
    logic [ID_W-1:0]  r_err_id;
    logic [ID_W-1:0]  r_win;
    logic [ID_W-1:0]  r_last;
    logic [CNT_W-1:0] r_cnt;
    // Set on a watchdog abort: the responder may still answer that abandoned request, so an
    // m_ack is not trusted again until it has been observed low.
    logic             r_stale;

    state_t           w_state_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [N_REQ-1:0] w_ack_nxt;
    logic             w_m_req_nxt;
    logic             w_terr_nxt;
    logic [ID_W-1:0]  w_err_id_nxt;
    logic [ID_W-1:0]  w_win_nxt;
    logic [ID_W-1:0]  w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stale_nxt;

    logic             w_any;
    logic [ID_W-1:0]  w_pick;
    logic [ID_W-1:0]  w_idx;
    logic             w_win_req;
    logic             w_wdog_exp;
    logic             w_ack_ok;

    // Round-robin search starting at r_last+1. Walking k downwards lets the smallest
    // offset (highest priority) overwrite earlier candidates.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last) + k) % N_REQ);
            if (req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    // r_gnt is one-hot while a transaction is open, so masking gives req[winner].
    assign w_win_req  = |(req & r_gnt);
    assign w_wdog_exp = (TIMEOUT != 0) && (r_cnt == CNT_MAX);
    assign w_ack_ok   = m_ack && !r_stale;

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_ack_nxt    = r_ack;
        w_m_req_nxt  = r_m_req;
        w_terr_nxt   = 1'b0;
        w_err_id_nxt = r_err_id;
        w_win_nxt    = r_win;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        w_stale_nxt  = r_stale && m_ack;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_REQ;
                    w_gnt_nxt   = N_REQ'(1) << w_pick;
                    w_m_req_nxt = 1'b1;
                    w_win_nxt   = w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_REQ: begin
                // Responder answer wins over requester abort, which wins over the watchdog.
                if (w_ack_ok) begin
                    w_ack_nxt   = r_gnt;
                    w_state_nxt = ST_ACK;
                end else if (!w_win_req) begin
                    w_m_req_nxt = 1'b0;
                    w_state_nxt = ST_REL;
                end else if (w_wdog_exp) begin
                    w_m_req_nxt  = 1'b0;
                    w_gnt_nxt    = '0;
                    w_terr_nxt   = 1'b1;
                    w_err_id_nxt = r_win;
                    w_stale_nxt  = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_ACK: begin
                if (!w_win_req) begin
                    w_m_req_nxt = 1'b0;
                    w_ack_nxt   = '0;
                    w_state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                if (!m_ack) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_ack_nxt   = '0;
                w_m_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_m_req  <= 1'b0;
            r_busy   <= 1'b0;
            r_terr   <= 1'b0;
            r_err_id <= '0;
            r_win    <= '0;
            r_last   <= ID_W'(N_REQ - 1);
            r_cnt    <= '0;
            r_stale  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ack    <= w_ack_nxt;
            r_m_req  <= w_m_req_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_terr   <= w_terr_nxt;
            r_err_id <= w_err_id_nxt;
            r_win    <= w_win_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stale  <= w_stale_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign ack         = r_ack;
    assign m_req       = r_m_req;
    assign busy        = r_busy;
    assign timeout_err = r_terr;
    assign err_id      = r_err_id;

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Purpose : self-checking bench for req_ack_arbiter (N_REQ=4, TIMEOUT=16).
// Latency : inputs driven 1ns after a rising edge, outputs sampled 1ns after the next one.
// Flow    : directed vector table, hand-written corner sequences, then random traffic vs a model.
module tb_req_ack_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] gnt;
    logic       m_req;
    logic       m_ack;
    logic       busy;
    logic       timeout_err;
    logic [1:0] err_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    req_ack_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .gnt(gnt), .m_req(m_req),
        .m_ack(m_ack), .busy(busy), .timeout_err(timeout_err), .err_id(err_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic ma);
        req   = r;
        m_ack = ma;
        @(posedge clk);
        #1;
    endtask

    // responder state for random traffic
    bit rs_armed;
    int rs_cnt;

    task automatic do_reset();
        req      = '0;
        m_ack    = 1'b0;
        rst_n    = 1'b1;
        rs_armed = 1'b0;
        rs_cnt   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    // ---------------- reference model (transaction view) ----------------
    int md_owner;     // granted requester, -1 when nothing is granted
    int md_last;
    int md_wait;      // cycles spent waiting for the responder
    int md_err_id;
    bit md_acked;     // ack given to owner, waiting for owner to drop req
    bit md_rel;       // downstream req withdrawn, waiting for m_ack low
    bit md_stale;
    bit md_terr;

    task automatic model_reset();
        md_owner  = -1;
        md_last   = N - 1;
        md_wait   = 0;
        md_err_id = 0;
        md_acked  = 1'b0;
        md_rel    = 1'b0;
        md_stale  = 1'b0;
        md_terr   = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic ma);
        bit stale_set;
        bit found;
        int c;
        stale_set = 1'b0;
        found     = 1'b0;
        md_terr   = 1'b0;
        if (md_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (md_last + k) % N;
                if (!found && r[c]) begin
                    found    = 1'b1;
                    md_owner = c;
                    md_last  = c;
                    md_wait  = 0;
                end
            end
        end else if (md_rel) begin
            if (!ma) begin
                md_owner = -1;
                md_rel   = 1'b0;
            end
        end else if (md_acked) begin
            if (!r[md_owner]) begin
                md_acked = 1'b0;
                md_rel   = 1'b1;
            end
        end else begin
            if (ma && !md_stale) md_acked = 1'b1;
            else if (!r[md_owner]) md_rel = 1'b1;
            else if (md_wait == TO - 1) begin
                md_terr   = 1'b1;
                md_err_id = md_owner;
                md_owner  = -1;
                stale_set = 1'b1;
            end else md_wait++;
        end
        md_stale = stale_set ? 1'b1 : (ma ? md_stale : 1'b0);
    endtask

    // ---------------- round-robin sequence ----------------
    // Requesters in 'want' keep asking; each drops req on ack and re-asks once its grant is gone.
    // Responder acks one cycle after m_req. Checks grant order and single-cycle IDLE gaps.
    task automatic rr_run(input string tag, input logic [3:0] want, input int n_exp,
                          input logic [19:0] order);
        logic [3:0] seen;
        logic [3:0] prev_gnt;
        logic [3:0] r;
        logic [3:0] e;
        int got;
        int gap;
        int ncyc;
        seen     = '0;
        prev_gnt = '0;
        got      = 0;
        gap      = 0;
        ncyc     = 0;
        while (got < n_exp && ncyc < 200) begin
            for (int i = 0; i < N; i++) begin
                if (ack[i]) seen[i] = 1'b1;
                if (!gnt[i]) seen[i] = 1'b0;
            end
            r = want & ~(gnt & seen);
            cyc(r, m_req);
            ncyc++;
            if (gnt != 4'b0000 && gnt != prev_gnt) begin
                got++;
                e = 4'b0001 << order[4*(got-1) +: 4];
                chk($sformatf("%s_grant%0d", tag, got), 32'(gnt), 32'(e));
                if (got > 1) chk($sformatf("%s_idle_gap%0d", tag, got), gap, 1);
                gap = 0;
            end else if (gnt == 4'b0000) begin
                gap++;
            end
            prev_gnt = gnt;
        end
        chk({tag, "_grants_seen"}, got, n_exp);
    endtask

    typedef struct {
        logic [3:0] req;
        logic       m_ack;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       m_req;
        logic       busy;
    } vec_t;

    vec_t vt [8];

    initial begin
        int hi;
        logic [3:0] r;
        logic [3:0] eg;
        logic [3:0] ea;
        logic       ma;

        // single requester 2, responder acks 3 cycles after m_req, req drops 1 cycle after ack
        vt[0] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1};
        vt[1] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1};
        vt[2] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1};
        vt[3] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1};
        vt[4] = '{4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vt[5] = '{4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vt[6] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[7] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        m_ack = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_gnt",   32'(gnt), 0);
        chk("reset_ack",   32'(ack), 0);
        chk("reset_m_req", 32'(m_req), 0);
        chk("reset_busy",  32'(busy), 0);
        chk("reset_terr",  32'(timeout_err), 0);
        chk("reset_errid", 32'(err_id), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // ---- table-driven single-requester transaction ----
        for (int i = 0; i < 8; i++) begin
            cyc(vt[i].req, vt[i].m_ack);
            chk($sformatf("vec%0d_gnt", i),   32'(gnt),   32'(vt[i].gnt));
            chk($sformatf("vec%0d_ack", i),   32'(ack),   32'(vt[i].ack));
            chk($sformatf("vec%0d_m_req", i), 32'(m_req), 32'(vt[i].m_req));
            chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(vt[i].busy));
        end

        // ---- round-robin: all four requesting -> 0,1,2,3,0 ----
        do_reset();
        rr_run("rr", 4'b1111, 5, 20'h03210);

        // ---- fairness after reset: 1010 -> 1,3,1 ----
        do_reset();
        rr_run("fair", 4'b1010, 3, 20'h00131);

        // ---- watchdog: requester 1, responder silent ----
        do_reset();
        cyc(4'b0010, 1'b0);
        chk("to_first_gnt", 32'(gnt), 32'h2);
        hi = m_req ? 1 : 0;
        for (int c = 0; c < 40; c++) begin
            cyc(4'b0010, 1'b0);
            if (m_req) hi++;
            else break;
        end
        chk("to_mreq_cycles", hi, TO);
        chk("to_terr",   32'(timeout_err), 1);
        chk("to_err_id", 32'(err_id), 1);
        chk("to_gnt",    32'(gnt), 0);
        chk("to_busy",   32'(busy), 0);
        // late m_ack arrives while idle; requester 1 is re-granted after one IDLE cycle
        cyc(4'b0010, 1'b1);
        chk("to_terr_pulse", 32'(timeout_err), 0);
        chk("to_regrant",    32'(gnt), 32'h2);
        chk("to_errid_hold", 32'(err_id), 1);
        cyc(4'b0010, 1'b1);
        chk("stale_ignored1", 32'(ack), 0);
        cyc(4'b0010, 1'b1);
        chk("stale_ignored2", 32'(ack), 0);
        cyc(4'b0010, 1'b0);
        chk("stale_cleared", 32'(ack), 0);
        cyc(4'b0010, 1'b1);
        chk("fresh_ack", 32'(ack), 32'h2);
        cyc(4'b0000, 1'b1);
        chk("fresh_rel_mreq", 32'(m_req), 0);
        cyc(4'b0000, 1'b0);
        chk("fresh_idle", 32'(busy), 0);

        // ---- requester abort ----
        do_reset();
        cyc(4'b1000, 1'b0);
        chk("ab_gnt", 32'(gnt), 32'h8);
        cyc(4'b0000, 1'b0);
        chk("ab_mreq_low", 32'(m_req), 0);
        chk("ab_rel_gnt",  32'(gnt), 32'h8);
        chk("ab_ack0",     32'(ack), 0);
        cyc(4'b0000, 1'b1);
        chk("ab_rel_hold1", 32'(busy), 1);
        chk("ab_ack1",      32'(ack), 0);
        cyc(4'b0000, 1'b1);
        chk("ab_rel_hold2", 32'(gnt), 32'h8);
        chk("ab_ack2",      32'(ack), 0);
        cyc(4'b0000, 1'b0);
        chk("ab_idle_gnt",  32'(gnt), 0);
        chk("ab_idle_busy", 32'(busy), 0);

        // ---- reset in the middle of ACK ----
        do_reset();
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b1);
        chk("mid_in_ack", 32'(ack), 32'h4);
        #2;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_gnt",  32'(gnt), 0);
        chk("mid_rst_ack",  32'(ack), 0);
        chk("mid_rst_mreq", 32'(m_req), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        #2;
        rst_n = 1'b0;
        req   = 4'b0001;
        m_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_after_gnt", 32'(gnt), 32'h1);

        // ---- random traffic vs model ----
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            r = req;
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if (!ack[i] && $urandom_range(0, 3) == 0) r[i] = 1'b1;
                end else if (ack[i]) begin
                    if ($urandom_range(0, 1) == 0) r[i] = 1'b0;
                end else if (gnt[i] && m_req && $urandom_range(0, 31) == 0) begin
                    r[i] = 1'b0;
                end
            end
            ma = m_ack;
            if (rs_armed) begin
                if (rs_cnt == 0) begin
                    ma       = 1'b1;
                    rs_armed = 1'b0;
                end else rs_cnt--;
            end else if (!m_ack && m_req) begin
                rs_armed = 1'b1;
                rs_cnt   = $urandom_range(0, 20);
            end
            if (m_ack && !m_req && $urandom_range(0, 1) == 0) ma = 1'b0;

            model_step(r, ma);
            cyc(r, ma);
            eg = (md_owner >= 0) ? (4'b0001 << md_owner) : 4'b0000;
            ea = md_acked ? eg : 4'b0000;
            chk($sformatf("rand%0d_gnt", n),   32'(gnt),   32'(eg));
            chk($sformatf("rand%0d_ack", n),   32'(ack),   32'(ea));
            chk($sformatf("rand%0d_m_req", n), 32'(m_req), 32'(md_owner >= 0 && !md_rel));
            chk($sformatf("rand%0d_busy", n),  32'(busy),  32'(md_owner >= 0));
            chk($sformatf("rand%0d_terr", n),  32'(timeout_err), 32'(md_terr));
            chk($sformatf("rand%0d_errid", n), 32'(err_id), 32'(md_err_id));
            if (failures > 20) break;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_ack_arbiter.md
Name: req_ack_arbiter

Overview:
- Round-robin arbiter that shares one downstream four-phase req/ack responder among N_REQ upstream requesters.
- Sits between the requesters and the existing req/ack responder. Drives the responder's req and returns its ack to the granted requester only.
- A watchdog aborts any transaction whose downstream ack does not arrive within TIMEOUT cycles and reports it.

Parameters:
N_REQ, 4, number of upstream requesters (2..16)
TIMEOUT, 16, max cycles in REQ state waiting for m_ack; 0 disables watchdog
ID_W, $clog2(N_REQ), width of requester index (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-high
req  input  N_REQ  upstream requests, bit i from requester i, level, four-phase
ack  output  N_REQ  upstream acks, at most one bit high
gnt  output  N_REQ  one-hot grant, all zero when idle
m_req  output  1  request to shared responder
m_ack  input  1  ack from shared responder
busy  output  1  high in any state other than IDLE
timeout_err  output  1  one-cycle pulse on watchdog abort
err_id  output  ID_W  index of requester aborted by last timeout; holds value until next timeout

Behaviour:
- Reset: rst_n = 1 clears all outputs to 0 asynchronously, regardless of state (including mid-transaction). Reset also clears the FSM to IDLE, the watchdog counter to 0 and last_winner to N_REQ-1, so req[0] has first priority after reset.
- All outputs are registered. There is no combinational path from req or m_ack to any output.
- Four-phase protocol, upstream and downstream: raise req, see ack, drop req, see ack drop.
- FSM states: IDLE, REQ, ACK, REL.
- IDLE:
  - If any req bit is high at the clock edge, pick the winner as the first set bit searching from last_winner+1 upward with wrap-around.
  - On that edge: gnt[winner]<=1, m_req<=1, last_winner<=winner, counter<=0, state goes to REQ.
  - Latency: req sampled high at edge k gives gnt and m_req high from edge k.
- REQ (m_req=1):
  - If m_ack=1: ack[winner]<=1, go to ACK.
  - Else if req[winner]=0 (requester abort): m_req<=0, go to REL.
  - Else if TIMEOUT!=0 and counter=TIMEOUT-1: m_req<=0, gnt<=0, timeout_err<=1 for one cycle, err_id<=winner, go to IDLE.
  - Else counter increments.
  - Priority when several conditions hold: m_ack, then abort, then timeout.
- ACK (m_req=1, ack[winner]=1): hold until req[winner]=0, then m_req<=0, ack[winner]<=0, go to REL.
- REL (m_req=0): wait for m_ack=0, then gnt<=0 and go to IDLE. REL has no watchdog.
- Minimum of one IDLE cycle between grants. Back-to-back grants are therefore at least one cycle apart.
- Requests from non-winners are ignored until the FSM returns to IDLE. They stay pending as long as their req stays high.
- A late m_ack arriving after a timeout (FSM in IDLE) is ignored. The next grant's REQ does not complete on that stale m_ack until m_ack has been seen low; a sticky flag is cleared when m_ack=0.
- Invariants:
  - gnt is one-hot or zero.
  - ack is only ever set at the gnt bit.
  - m_req=1 implies gnt is nonzero.
  - busy=0 implies gnt=0, ack=0 and m_req=0.

Test Plan:
- Single requester: N_REQ=4, req[2] raised; responder acks 3 cycles after m_req; req[2] drops 1 cycle after ack. Required: gnt=4'b0100 from the sampling edge, ack[2] one cycle after m_ack, m_req and ack[2] low one cycle after req[2] drops, gnt=0 and busy=0 once m_ack is low.
- Round-robin: req=4'b1111 held, each transaction completed. Required grant order 0,1,2,3,0, with exactly one IDLE cycle between grants.
- Fairness after reset: req=4'b1010 from reset. Required: first grant to 1, then 3, then 1.
- Timeout: TIMEOUT=16, m_ack tied 0, req[1] high. Required: m_req high for exactly 16 cycles, then timeout_err pulse of 1 cycle, err_id=1, gnt=0; req[1] is re-granted after one IDLE cycle.
- Abort: req[3] drops in REQ before m_ack. Required: m_req low next cycle, no ack[3] ever asserted, FSM in REL until m_ack=0, then IDLE.
- Reset mid-operation: rst_n pulsed high while in ACK. Required: all outputs 0 immediately (before the next clock edge); after release with req[0] high, gnt=4'b0001.
